// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch into IF/ID; define FETCH_PERF_EN for fetch/stall counters
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc_plus_4,
`ifdef FETCH_PERF_EN
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_stall_count,
`endif
  output logic        o_valid
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  state_t state, state_d;
  logic [31:0] fetch_pc, pc_d, target;
  logic drop, drop_d, load, clr, keep_wait;
  assign target = i_redirect_pc & ~32'h3;
  assign keep_wait = (state == WAIT && !i_imem_rvalid) || (state == REQ && i_imem_gnt);
  assign o_imem_req = state == REQ;
  assign o_imem_addr = fetch_pc;
  always_comb begin
    state_d = state;
    pc_d = fetch_pc;
    drop_d = drop;
    load = 1'b0;
    clr = 1'b0;
    case (state)
      IDLE: state_d = REQ;
      REQ: state_d = i_imem_gnt ? WAIT : REQ;
      WAIT: if (i_imem_rvalid) begin
        drop_d = 1'b0;
        load = !drop;
        pc_d = drop ? fetch_pc : fetch_pc + 32'd4;
        state_d = drop ? REQ : HOLD;
      end
      HOLD: begin
        clr = !i_stall;
        state_d = i_stall ? HOLD : REQ;
      end
      default: state_d = IDLE;
    endcase
    // an accepted or in-flight request must still be retired, so its response is marked stale
    if (i_redirect) begin
      pc_d = target;
      load = 1'b0;
      clr = 1'b1;
      drop_d = keep_wait;
      state_d = keep_wait ? WAIT : REQ;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      drop <= 1'b0;
    end else begin
      state <= state_d;
      fetch_pc <= pc_d;
      drop <= drop_d;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_pc <= RESET_PC;
      o_instruction <= 32'h00000013;
      o_pc_plus_4 <= RESET_PC + 32'd4;
    end else if (load) begin
      o_valid <= 1'b1;
      o_pc <= fetch_pc;
      o_instruction <= i_imem_rdata;
      o_pc_plus_4 <= fetch_pc + 32'd4;
    end else if (clr) begin
      o_valid <= 1'b0;
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_fetch_count <= 32'd0;
      o_stall_count <= 32'd0;
    end else begin
      o_fetch_count <= o_fetch_count + {31'd0, o_valid && !i_stall};
      o_stall_count <= o_stall_count + {31'd0, o_valid && i_stall};
    end
  end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table, reset/wrap sequences, and randomized memory against a program-order model
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hA5A50000;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect = 1'b0, gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] redirect_pc = '0, rdata = '0;
  logic req, valid;
  logic [31:0] addr, pc, instr, pp4;
  logic req2, valid2, gnt2;
  logic rv2 = 1'b0;
  logic [31:0] addr2, pc2, instr2, pp42;
  logic [31:0] rdata2 = '0;
`ifdef FETCH_PERF_EN
  logic [31:0] fc, sc;
`endif
  int checks = 0, failures = 0;

  typedef struct {
    logic stall, redir;
    logic [31:0] rpc;
    logic gnt, rv;
    logic [31:0] rdata;
    logic e_req;
    logic [31:0] e_addr;
    logic e_valid;
    logic [31:0] e_pc, e_instr;
  } vec_t;
  vec_t tbl[24];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_pc(pc), .o_instruction(instr), .o_pc_plus_4(pp4),
`ifdef FETCH_PERF_EN
    .o_fetch_count(fc), .o_stall_count(sc),
`endif
    .o_valid(valid)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fc2, sc2;
`endif
  fetch_unit #(.RESET_PC(32'hFFFFFFFC)) u_wrap (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(1'b0), .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_imem_req(req2), .o_imem_addr(addr2), .i_imem_gnt(gnt2), .i_imem_rvalid(rv2), .i_imem_rdata(rdata2),
    .o_pc(pc2), .o_instruction(instr2), .o_pc_plus_4(pp42),
`ifdef FETCH_PERF_EN
    .o_fetch_count(fc2), .o_stall_count(sc2),
`endif
    .o_valid(valid2)
  );

  // zero-wait memory for the wrap-around instance
  assign gnt2 = req2;
  always @(posedge clk) begin
    rv2 <= gnt2;
    rdata2 <= addr2 ^ 32'h13579BDF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    gnt = 1'b0; rvalid = 1'b0; rdata = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_pc, oaddr;
    bit outst, prev_cons, timed_out;
    int lat, idle, cons, stl;
    //             stall redir rpc        gnt rv rdata          req addr       valid pc         instr
    tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h0,   NOP};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,     1'b1, 32'h0,   1'b0, 32'h0,   NOP};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, K,         1'b0, 32'h0,   1'b0, 32'h0,   NOP};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h0,   K};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,     1'b1, 32'h4,   1'b0, 32'h0,   K};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, K|32'h4,   1'b0, 32'h0,   1'b0, 32'h0,   K};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h4,   K|32'h4};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h4,   K|32'h4};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h4,   K|32'h4};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h4,   K|32'h4};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h4,   K|32'h4};
    tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,     1'b1, 32'h8,   1'b0, 32'h4,   K|32'h4};
    tbl[12] = '{1'b0, 1'b1, 32'h103, 1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h4,   K|32'h4};
    tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b0, 32'h4,   K|32'h4};
    tbl[14] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, K|32'h8,   1'b0, 32'h0,   1'b0, 32'h4,   K|32'h4};
    tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,     1'b1, 32'h100, 1'b0, 32'h4,   K|32'h4};
    tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, K|32'h100, 1'b0, 32'h0,   1'b0, 32'h4,   K|32'h4};
    tbl[17] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h100, K|32'h100};
    tbl[18] = '{1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,     1'b1, 32'h104, 1'b0, 32'h100, K|32'h100};
    tbl[19] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, K|32'h104, 1'b0, 32'h0,   1'b0, 32'h100, K|32'h100};
    tbl[20] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,     1'b1, 32'h200, 1'b0, 32'h100, K|32'h100};
    tbl[21] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, K|32'h200, 1'b0, 32'h0,   1'b0, 32'h100, K|32'h100};
    tbl[22] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,     1'b0, 32'h0,   1'b1, 32'h200, K|32'h200};
    tbl[23] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,     1'b1, 32'h204, 1'b0, 32'h200, K|32'h200};

    apply_reset;
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("tbl%0d_req", i), {31'd0, req}, {31'd0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].e_instr);
      chk($sformatf("tbl%0d_pc_plus_4", i), pp4, tbl[i].e_pc + 32'd4);
      if (i == 3) begin
        chk("wrap_valid", {31'd0, valid2}, 32'd1);
        chk("wrap_pc", pc2, 32'hFFFFFFFC);
        chk("wrap_pc_plus_4", pp42, 32'h0);
        chk("wrap_instr", instr2, 32'hFFFFFFFC ^ 32'h13579BDF);
      end
      if (i == 4) begin
        chk("wrap_next_req", {31'd0, req2}, 32'd1);
        chk("wrap_next_addr", addr2, 32'h0);
      end
      stall = tbl[i].stall; redirect = tbl[i].redir; redirect_pc = tbl[i].rpc;
      gnt = tbl[i].gnt; rvalid = tbl[i].rv; rdata = tbl[i].rdata;
      @(negedge clk);
    end

    // reset while a request is outstanding; the response lands during and after reset
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc_plus_4", pp4, 32'h4);
    rvalid = 1'b1; rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("rst_rv_valid", {31'd0, valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", {31'd0, req}, 32'd1);
    chk("post_rst_addr", addr, 32'h0);
    chk("post_rst_valid", {31'd0, valid}, 32'd0);
    @(negedge clk);
    chk("late_rv_valid", {31'd0, valid}, 32'd0);
    chk("late_rv_instr", instr, NOP);
    rvalid = 1'b0;

    // randomized memory latency, stalls and redirects against a program-order model
    apply_reset;
    exp_pc = 32'h0; outst = 1'b0; prev_cons = 1'b0; timed_out = 1'b0;
    lat = 0; idle = 0; cons = 0; stl = 0; oaddr = '0;
    for (int c = 0; c < 4000; c++) begin
      chk("rnd_req_while_outstanding", {31'd0, req & outst}, 32'd0);
      if (prev_cons) chk("rnd_valid_one_cycle", {31'd0, valid}, 32'd0);
      stall = ($urandom % 4) == 0;
      redirect = ($urandom % 16) == 0;
      redirect_pc = $urandom;
      if (valid && !stall) begin
        chk("rnd_pc", pc, exp_pc);
        chk("rnd_instr", instr, exp_pc ^ K);
        chk("rnd_pc_plus_4", pp4, exp_pc + 32'd4);
        exp_pc += 32'd4;
        cons++;
        idle = 0;
      end else idle++;
      if (valid && stall) stl++;
      prev_cons = valid && !stall;
      if (redirect) exp_pc = redirect_pc & ~32'h3;
      if (idle > 150 && !timed_out) begin
        timed_out = 1'b1;
        checks++; failures++;
        $display("FAIL rnd_progress: no instruction delivered for %0d cycles, expected delivery within 150", idle);
      end
      rvalid = 1'b0; gnt = 1'b0; rdata = $urandom;
      if (outst) begin
        lat--;
        if (lat == 0) begin
          rvalid = 1'b1; rdata = oaddr ^ K; outst = 1'b0;
        end
      end else if (req) begin
        gnt = ($urandom % 3) != 0;
        if (gnt) begin
          outst = 1'b1; oaddr = addr; lat = $urandom_range(3, 1);
        end
      end
      @(negedge clk);
    end
    chk("rnd_delivered_some", {31'd0, cons > 100}, 32'd1);
`ifdef FETCH_PERF_EN
    chk("fetch_count", fc, cons);
    chk("stall_count", sc, stl);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
